// File: rtl/esn_snap_reader.sv
// -----------------------------------------------------------------------------
// esn_snap_reader
// Snapshot reader for the ESN readout. On a request it copies the readout
// estimate and all NW learned weights into shadow registers in one cycle, then
// streams them as an (NW+1)-word frame over a valid/ready interface:
// word 0 is the estimate, words 1..NW are the weights 0..NW-1.
// The readout is never stalled; requests arriving while a frame is in flight
// are counted as drops and otherwise ignored.
//
// Ports:
//   clk        system clock
//   rst_N      asynchronous active-low reset
//   W_in       NW*DW learned weights, word k = W_in[k*DW +: DW]
//   est_in     DW readout estimate
//   snap_req   snapshot request (pulse or level)
//   out_data   current frame word
//   out_idx    index of out_data within the frame (0..NW)
//   out_valid  out_data/out_idx/out_last valid
//   out_ready  consumer accepts the word when high together with out_valid
//   out_last   high with the final word (idx NW)
//   busy       frame in progress
//   drop_cnt   requests ignored while busy, saturating at 255
//   frame_cnt  completed frames, wrapping
// -----------------------------------------------------------------------------
module esn_snap_reader #(
  parameter int NW = 8,
  parameter int DW = 32,
  parameter int IW = 4
) (
  input  logic             clk,
  input  logic             rst_N,
  input  logic [NW*DW-1:0] W_in,
  input  logic [DW-1:0]    est_in,
  input  logic             snap_req,
  output logic [DW-1:0]    out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [7:0]       drop_cnt,
  output logic [15:0]      frame_cnt
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SEND  = 1'b1;
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NW);

  logic [0:0]       state_q,     state_d;
  logic [IW-1:0]    idx_q,       idx_d;
  logic [DW-1:0]    out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic             busy_q,      busy_d;
  logic [7:0]       drop_cnt_q,  drop_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]    est_sh_q,    est_sh_d;
  logic [NW*DW-1:0] w_sh_q,      w_sh_d;
  logic             handshake_s;

  // Weight word i of a packed weight vector; indices >= NW return zero.
  function automatic logic [DW-1:0] sel_word(input logic [NW*DW-1:0] w,
                                             input logic [IW-1:0]    i);
    logic [DW-1:0] r;
    r = {DW{1'b0}};
    for (int k = 0; k < NW; k++) begin
      if (i == IW'(k)) begin
        r = w[k*DW +: DW];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign handshake_s = out_valid_q & out_ready;

  // Next-state logic: capture, word sequencing, drop and frame counting.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    drop_cnt_d  = drop_cnt_q;
    frame_cnt_d = frame_cnt_q;
    est_sh_d    = est_sh_q;
    w_sh_d      = w_sh_q;

    case (state_q)
      ST_IDLE: begin
        if (snap_req) begin
          // Atomic capture; word 0 (the estimate) is presented straight away
          // from the input so the first word is valid one cycle later.
          est_sh_d    = est_in;
          w_sh_d      = W_in;
          state_d     = ST_SEND;
          idx_d       = {IW{1'b0}};
          out_data_d  = est_in;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEND: begin
        // A request during a frame never touches the shadows, only the counter.
        if (snap_req && (drop_cnt_q != 8'hFF)) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
          drop_cnt_d = drop_cnt_q;
        end

        if (handshake_s) begin
          if (idx_q == IDX_LAST) begin
            state_d     = ST_IDLE;
            idx_d       = {IW{1'b0}};
            out_data_d  = {DW{1'b0}};
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            // Frame word idx+1 is weight word idx.
            idx_d      = idx_q + IDX_ONE;
            out_data_d = sel_word(w_sh_q, idx_q);
            out_last_d = ((idx_q + IDX_ONE) == IDX_LAST);
          end
        end else begin
          state_d = ST_SEND;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        idx_d       = {IW{1'b0}};
        out_data_d  = {DW{1'b0}};
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, output and shadow registers.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state_q     <= ST_IDLE;
      idx_q       <= {IW{1'b0}};
      out_data_q  <= {DW{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      drop_cnt_q  <= 8'd0;
      frame_cnt_q <= 16'd0;
      est_sh_q    <= {DW{1'b0}};
      w_sh_q      <= {(NW*DW){1'b0}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      est_sh_q    <= est_sh_d;
      w_sh_q      <= w_sh_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_cnt_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_esn_snap_reader.sv
// -----------------------------------------------------------------------------
// tb_esn_snap_reader
// Self-checking bench for esn_snap_reader (NW=8, DW=32, IW=4). A table of
// per-cycle {inputs, expected outputs} records covers a plain frame and a
// back-pressured frame; hand-written sequences cover input changes during a
// frame, drops and saturation, continuous requests, frame counter wrap and
// an asynchronous reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_esn_snap_reader;

  localparam int NW = 8;
  localparam int DW = 32;
  localparam int IW = 4;

  logic             clk;
  logic             rst_N;
  logic [NW*DW-1:0] W_in;
  logic [DW-1:0]    est_in;
  logic             snap_req;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic [7:0]       drop_cnt;
  logic [15:0]      frame_cnt;

  esn_snap_reader #(.NW(NW), .DW(DW), .IW(IW)) dut (
    .clk       (clk),
    .rst_N     (rst_N),
    .W_in      (W_in),
    .est_in    (est_in),
    .snap_req  (snap_req),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .drop_cnt  (drop_cnt),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        snap;
    logic        rdy;
    logic        e_valid;
    logic [3:0]  e_idx;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected frame word for the basic input pattern.
  function automatic logic [31:0] exp_word(input int e);
    return (e == 0) ? 32'h0000_00AA : (32'h1000_0000 + 32'(e - 1));
  endfunction

  task automatic set_basic();
    est_in = 32'h0000_00AA;
    for (int k = 0; k < NW; k++) W_in[k*DW +: DW] = 32'h1000_0000 + 32'(k);
  endtask

  // Append one frame: ready is high on every rdy_mod-th cycle (1 = always).
  function automatic void add_frame(input int rdy_mod);
    int   e;
    logic r;
    vec_t v;
    v = '{1'b1, 1'b1, 1'b1, 4'd0, exp_word(0), 1'b0, 1'b1};
    vecs.push_back(v);
    e = 0;
    for (int j = 0; j < 100; j++) begin
      r = ((j % rdy_mod) == 0);
      if (r && e == NW) begin
        v = '{1'b0, r, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0};
        vecs.push_back(v);
        break;
      end
      if (r) e++;
      v = '{1'b0, r, 1'b1, 4'(e), exp_word(e), (e == NW), 1'b1};
      vecs.push_back(v);
    end
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 32'(out_valid), 32'd0);
    chk({tag, " busy"},  32'(busy),      32'd0);
    chk({tag, " idx"},   32'(out_idx),   32'd0);
    chk({tag, " last"},  32'(out_last),  32'd0);
  endtask

  initial begin
    logic [31:0] cap [NW+1];
    int          hs;
    int          fc0;
    int          starts[$];
    int          gap1;
    int          gap2;

    rst_N     = 1'b0;
    snap_req  = 1'b0;
    out_ready = 1'b0;
    set_basic();

    // Reset values, no clock edge needed.
    #12;
    chk_idle("reset");
    chk("reset data",      32'(out_data),  32'd0);
    chk("reset drop_cnt",  32'(drop_cnt),  32'd0);
    chk("reset frame_cnt", 32'(frame_cnt), 32'd0);
    #5 rst_N = 1'b1;
    step();
    chk_idle("post-release");

    // Table: basic frame, then a back-pressured frame (ready 1,0,0,1,...).
    add_frame(1);
    add_frame(3);
    hs = 0;
    foreach (vecs[i]) begin
      snap_req  = vecs[i].snap;
      out_ready = vecs[i].rdy;
      if (out_valid && out_ready) hs++;
      step();
      chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d idx",   i), 32'(out_idx),   32'(vecs[i].e_idx));
      chk($sformatf("vec%0d data",  i), out_data,       vecs[i].e_data);
      chk($sformatf("vec%0d last",  i), 32'(out_last),  32'(vecs[i].e_last));
      chk($sformatf("vec%0d busy",  i), 32'(busy),      32'(vecs[i].e_busy));
    end
    snap_req = 1'b0;
    chk("table handshakes", 32'(hs), 32'd18);
    chk("table frame_cnt",  32'(frame_cnt), 32'd2);
    chk("table drop_cnt",   32'(drop_cnt),  32'd0);

    // Inputs scrambled every cycle after capture; frame must hold captured values.
    est_in = 32'h0000_0055;
    for (int k = 0; k < NW; k++) W_in[k*DW +: DW] = 32'h2000_0000 + 32'(k * 7);
    cap[0] = 32'h0000_0055;
    for (int k = 0; k < NW; k++) cap[k+1] = 32'h2000_0000 + 32'(k * 7);
    out_ready = 1'b1;
    snap_req  = 1'b1;
    step();
    snap_req = 1'b0;
    for (int j = 0; j <= NW; j++) begin
      chk($sformatf("scramble idx%0d", j),  32'(out_idx), 32'(j));
      chk($sformatf("scramble data%0d", j), out_data,     cap[j]);
      est_in = $urandom;
      for (int k = 0; k < NW; k++) W_in[k*DW +: DW] = $urandom;
      step();
    end
    chk_idle("scramble end");
    chk("scramble frame_cnt", 32'(frame_cnt), 32'd3);

    // Three drops during a frame, the last on the final-handshake cycle.
    set_basic();
    snap_req = 1'b1;
    step();
    for (int j = 0; j <= NW; j++) begin
      chk($sformatf("drop idx%0d", j),  32'(out_idx), 32'(j));
      chk($sformatf("drop data%0d", j), out_data,     exp_word(j));
      snap_req = (j == 2 || j == 5 || j == NW);
      est_in   = snap_req ? 32'hDEAD_0000 : 32'h0000_00AA;
      step();
    end
    snap_req = 1'b0;
    set_basic();
    chk_idle("drop end");
    step();
    step();
    chk_idle("drop no restart");
    chk("drop_cnt 3",      32'(drop_cnt),  32'd3);
    chk("drop frame_cnt",  32'(frame_cnt), 32'd4);

    // 300 drops with ready low: saturate at 255.
    out_ready = 1'b0;
    snap_req  = 1'b1;
    step();
    for (int j = 0; j < 300; j++) step();
    chk("drop_cnt sat",     32'(drop_cnt), 32'd255);
    chk("sat still idx0",   32'(out_idx),  32'd0);
    chk("sat still data",   out_data,      32'h0000_00AA);
    snap_req  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j <= NW; j++) step();
    chk_idle("sat drain");
    chk("sat frame_cnt", 32'(frame_cnt), 32'd5);

    // Continuous request: frame starts every NW+2 cycles.
    fc0      = int'(frame_cnt);
    snap_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (out_valid && out_idx == 4'd0) starts.push_back(c);
    end
    snap_req = 1'b0;
    gap1 = (starts.size() >= 2) ? starts[1] - starts[0] : -1;
    gap2 = (starts.size() >= 3) ? starts[2] - starts[1] : -1;
    chk("cont starts",    32'(starts.size()), 32'd3);
    chk("cont gap1",      32'(gap1), 32'd10);
    chk("cont gap2",      32'(gap2), 32'd10);
    chk("cont frame_cnt", 32'(frame_cnt), 32'(fc0 + 3));
    chk("cont drop sat",  32'(drop_cnt), 32'd255);
    step();
    chk_idle("cont end");

    // Frame counter wrap 65535 -> 0.
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    step();
    chk("wrap preload", 32'(frame_cnt), 32'h0000_FFFF);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    for (int j = 0; j <= NW; j++) step();
    chk("wrap frame_cnt", 32'(frame_cnt), 32'd0);
    chk_idle("wrap end");

    // Async reset at idx 4 with ready low.
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    for (int j = 0; j < 4; j++) step();
    out_ready = 1'b0;
    step();
    chk("pre-reset idx",  32'(out_idx), 32'd4);
    chk("pre-reset data", out_data,     exp_word(4));
    #3 rst_N = 1'b0;
    #1;
    chk_idle("async reset");
    chk("async data",      out_data,         32'd0);
    chk("async drop_cnt",  32'(drop_cnt),    32'd0);
    chk("async frame_cnt", 32'(frame_cnt),   32'd0);
    #2 rst_N = 1'b1;
    out_ready = 1'b1;
    snap_req  = 1'b1;
    step();
    snap_req = 1'b0;
    for (int j = 0; j <= NW; j++) begin
      chk($sformatf("fresh idx%0d", j),  32'(out_idx),  32'(j));
      chk($sformatf("fresh data%0d", j), out_data,      exp_word(j));
      chk($sformatf("fresh last%0d", j), 32'(out_last), 32'(j == NW));
      step();
    end
    chk_idle("fresh end");
    chk("fresh frame_cnt", 32'(frame_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
